alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU between two requesters (port 0: integer execute path, port 1: address/auxiliary path). It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures the result, and returns it to the granted requester over a valid/ready response channel.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- OP_WIDTH, 4, opcode width; must match the ALU.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request valid, port N (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle, port N.
- reqN_opcode  in  OP_WIDTH  ALU opcode, port N.
- reqN_operand_0  in  DATA_WIDTH  first operand, port N.
- reqN_operand_1  in  DATA_WIDTH  second operand, port N.
- rspN_valid  out  1  response valid, port N.
- rspN_ready  in  1  response consumed, port N.
- rspN_result  out  DATA_WIDTH  result, port N.
- alu_opcode  out  OP_WIDTH  to the ALU opcode input.
- alu_operand_0  out  DATA_WIDTH  to the ALU first operand.
- alu_operand_1  out  DATA_WIDTH  to the ALU second operand.
- alu_result  in  DATA_WIDTH  from the ALU result (combinational).
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: grant (1 bit), prio (1 bit, port with priority next), op_reg, a_reg, b_reg, res_reg.
- IDLE: if exactly one reqN_valid, that port is granted. If both, port prio is granted. reqN_ready = 1 combinationally for the granted port only; the other ready stays 0. On handshake: capture opcode/operands into op_reg/a_reg/b_reg, latch grant, go to EXEC.
- EXEC: alu_* outputs reflect the captured registers. res_reg <= alu_result. Go to RESP.
- RESP: rsp[grant]_valid = 1, rsp[grant]_result = res_reg. The other port's rsp_valid = 0. On rsp[grant]_ready: prio <= ~grant, go to IDLE. The FSM holds RESP indefinitely while ready is low.
- All reqN_ready are 0 in EXEC and RESP. No request is accepted while busy.
- rspN_result is res_reg on both ports, and is qualified only by rspN_valid.
- alu_opcode, alu_operand_0 and alu_operand_1 are driven from op_reg, a_reg and b_reg at all times. They hold their last values in IDLE and RESP.
- Opcodes are passed through unmodified. An unsupported opcode yields the ALU's default result, 0, and is returned normally.
- Requesters must hold valid and payload stable until ready. If a request drops before ready, it is simply not granted.

## Timing
- Request handshake at edge T. EXEC occupies the cycle after T. rsp_valid is high in the cycle after EXEC, i.e. 2 cycles after acceptance.
- With rsp_ready held high, throughput is one operation per 3 cycles per arbiter. The next accept can occur in the cycle after the response handshake.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Reset values: state IDLE, prio 0, grant 0. op_reg, a_reg, b_reg and res_reg are 0. All rsp_valid and busy are 0. reqN_ready follows IDLE rules, so a valid request can be accepted in the first cycle after rst deasserts.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is issued. All outputs return to reset values on the next edge.
- rst has priority over any simultaneous handshake.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. Port 0 always wins when both request, and prio is unused (held 0). Port 1 can starve.
- Undefined (default): round-robin as described above.

## Test plan
- Single op: req0 ADD(0), 5, 7 accepted at T -> rsp0_valid at T+2, rsp0_result 12, rsp1_valid 0 throughout.
- Contention: req0 SUB(1), 10, 3 and req1 LESS_THAN(9), 0xFFFFFFFF, 1 valid together from reset -> port 0 served first (result 7), then port 1 (result 1). Grants continue alternating over 6 back-to-back ops.
- Backpressure: rsp1_ready low for 5 cycles after rsp1_valid -> result held stable, busy 1, req0_ready 0. On ready, the FSM returns to IDLE next cycle.
- Shift/default: port 1 SHR_ARITHMETIC(8), 0x80000000, 4 -> 0xF8000000. Opcode 4'b1111 -> result 0.
- Reset in EXEC: assert rst for 1 cycle during EXEC -> no rsp_valid ever for that op. All outputs 0. A new req0 is accepted the cycle after rst deasserts.
- With ALU_ARB_FIXED_PRIO_EN: both ports continuously valid -> port 0 granted every time, port 1 never granted.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response channels for both ALU ports plus the shared-ALU drive bus.
// The arbiter uses the slave modport; requesters and the ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [OP_WIDTH-1:0]   req0_opcode;
  logic [DATA_WIDTH-1:0] req0_operand_0;
  logic [DATA_WIDTH-1:0] req0_operand_1;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [OP_WIDTH-1:0]   req1_opcode;
  logic [DATA_WIDTH-1:0] req1_operand_0;
  logic [DATA_WIDTH-1:0] req1_operand_1;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic [DATA_WIDTH-1:0] rsp0_result;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp1_result;
  logic [OP_WIDTH-1:0]   alu_opcode;
  logic [DATA_WIDTH-1:0] alu_operand_0;
  logic [DATA_WIDTH-1:0] alu_operand_1;
  logic [DATA_WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_opcode, req0_operand_0, req0_operand_1,
    input  req1_valid, req1_opcode, req1_operand_0, req1_operand_1,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output alu_opcode, alu_operand_0, alu_operand_1
  );

  modport master (
    output req0_valid, req0_opcode, req0_operand_0, req0_operand_1,
    output req1_valid, req1_opcode, req1_operand_0, req1_operand_1,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  alu_opcode, alu_operand_0, alu_operand_1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic                  grant_r;
  logic                  prio_r;
  logic [OP_WIDTH-1:0]   op_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-1:0] res_r;
  logic                  busy_r;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;

  logic                  pick_s;
  logic                  accept_s;
  logic                  rsp_ready_s;

  // Port selection: a lone requester wins; on contention the priority port wins.
  always_comb begin
    pick_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      pick_s = 1'b0;
`else
      pick_s = prio_r;
`endif
    end else if (bus.req1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Request ready is only offered in IDLE and only to the selected port.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (state_r == IDLE) begin
      bus.req0_ready = bus.req0_valid & ~pick_s;
      bus.req1_ready = bus.req1_valid & pick_s;
    end else begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
    end
  end

  assign accept_s    = bus.req0_ready | bus.req1_ready;
  assign rsp_ready_s = grant_r ? bus.rsp1_ready : bus.rsp0_ready;

  // Sequencer: capture request, run the ALU for one cycle, hold the response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      prio_r       <= 1'b0;
      op_r         <= {OP_WIDTH{1'b0}};
      a_r          <= {DATA_WIDTH{1'b0}};
      b_r          <= {DATA_WIDTH{1'b0}};
      res_r        <= {DATA_WIDTH{1'b0}};
      busy_r       <= 1'b0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            grant_r <= pick_s;
            op_r    <= pick_s ? bus.req1_opcode    : bus.req0_opcode;
            a_r     <= pick_s ? bus.req1_operand_0 : bus.req0_operand_0;
            b_r     <= pick_s ? bus.req1_operand_1 : bus.req0_operand_1;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          res_r        <= bus.alu_result;
          rsp0_valid_r <= ~grant_r;
          rsp1_valid_r <= grant_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_ready_s) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            prio_r <= 1'b0;
`else
            prio_r <= ~grant_r;
`endif
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp0_valid    = rsp0_valid_r;
  assign bus.rsp1_valid    = rsp1_valid_r;
  assign bus.rsp0_result   = res_r;
  assign bus.rsp1_result   = res_r;
  assign bus.alu_opcode    = op_r;
  assign bus.alu_operand_0 = a_r;
  assign bus.alu_operand_1 = b_r;
  assign busy              = busy_r;

endmodule
